// File: rtl/communication_pkg.sv
`default_nettype none
// ============================================================================
// Module      : communication_pkg
// Description : Command codes and FSM state type for the UART/DDS decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package communication_pkg;

    localparam logic [7:0] c_CMD_BYTE0   = 8'h01;
    localparam logic [7:0] c_CMD_BYTE1   = 8'h02;
    localparam logic [7:0] c_CMD_BYTE2   = 8'h03;
    localparam logic [7:0] c_CMD_BYTE3   = 8'h04;
    localparam logic [7:0] c_CMD_SET     = 8'h05;
    localparam logic [7:0] c_CMD_ENABLE  = 8'h06;
    localparam logic [7:0] c_CMD_DISABLE = 8'h07;
    localparam logic [7:0] c_CMD_STATUS  = 8'h08;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    // BYTEn codes are contiguous, so the ack code is recovered from the index.
    function automatic logic [7:0] byte_cmd(input logic [1:0] idx);
        return c_CMD_BYTE0 + {6'b0, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/communication.sv
`default_nettype none
// ============================================================================
// Module      : communication
// Description : Byte command decoder loading the DDS phase increment and enable.
// Revision    : 1.0 - initial release
// ============================================================================
module communication
    import communication_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        received,
    input  logic [7:0]  rx_byte,
    output logic        transmit,
    output logic [7:0]  tx_byte,
    output logic        en,
    output logic [31:0] m,
    output logic        set
);

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_idx, w_idx_nxt;
    logic [31:0] r_sh, w_sh_nxt;
    logic [31:0] r_m, w_m_nxt;
    logic        r_en, w_en_nxt;
    logic        r_set, w_set_nxt;
    logic        r_tx, w_tx_nxt;
    logic [7:0]  r_txb, w_txb_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= 2'd0;
            r_sh    <= 32'd0;
            r_m     <= 32'd0;
            r_en    <= 1'b0;
            r_set   <= 1'b0;
            r_tx    <= 1'b0;
            r_txb   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_sh    <= w_sh_nxt;
            r_m     <= w_m_nxt;
            r_en    <= w_en_nxt;
            r_set   <= w_set_nxt;
            r_tx    <= w_tx_nxt;
            r_txb   <= w_txb_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_sh_nxt    = r_sh;
        w_m_nxt     = r_m;
        w_en_nxt    = r_en;
        w_set_nxt   = 1'b0;
        w_tx_nxt    = 1'b0;
        w_txb_nxt   = r_txb;
        if (received) begin
            case (r_state)
                ST_IDLE: begin
                    case (rx_byte)
                        c_CMD_BYTE0, c_CMD_BYTE1, c_CMD_BYTE2, c_CMD_BYTE3: begin
                            w_idx_nxt   = rx_byte[1:0] - 2'd1;
                            w_state_nxt = ST_DATA;
                        end
                        c_CMD_SET: begin
                            w_m_nxt   = r_sh;
                            w_set_nxt = 1'b1;
                            w_tx_nxt  = 1'b1;
                            w_txb_nxt = c_CMD_SET;
                        end
                        c_CMD_ENABLE, c_CMD_DISABLE: begin
                            w_en_nxt  = (rx_byte == c_CMD_ENABLE);
                            w_tx_nxt  = 1'b1;
                            w_txb_nxt = rx_byte;
                        end
                        c_CMD_STATUS: begin
                            w_tx_nxt  = 1'b1;
                            w_txb_nxt = {7'd0, r_en};
                        end
                        default: ;
                    endcase
                end
                ST_DATA: begin
                    // Any byte here is payload, even one that looks like a command.
                    case (r_idx)
                        2'd0:    w_sh_nxt[7:0]   = rx_byte;
                        2'd1:    w_sh_nxt[15:8]  = rx_byte;
                        2'd2:    w_sh_nxt[23:16] = rx_byte;
                        default: w_sh_nxt[31:24] = rx_byte;
                    endcase
                    w_state_nxt = ST_IDLE;
                    w_tx_nxt    = 1'b1;
                    w_txb_nxt   = byte_cmd(r_idx);
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign transmit = r_tx;
    assign tx_byte  = r_txb;
    assign en       = r_en;
    assign m        = r_m;
    assign set      = r_set;

endmodule
`default_nettype wire

// File: tb/tb_communication.sv
`default_nettype none
// ============================================================================
// Module      : tb_communication
// Description : Scoreboard bench for the communication command decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_communication;
    import communication_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        received = 1'b0;
    logic [7:0]  rx_byte = 8'd0;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic        en;
    logic [31:0] m;
    logic        set;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          set_cnt = 0;
    logic [7:0]  ack_q[$];
    int          tx_cyc_q[$];

    communication u_dut (
        .clk      (clk),
        .rst      (rst),
        .received (received),
        .rx_byte  (rx_byte),
        .transmit (transmit),
        .tx_byte  (tx_byte),
        .en       (en),
        .m        (m),
        .set      (set)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare each ack against the scoreboard as it leaves the DUT.
    always @(negedge clk) begin
        if (set === 1'b1) set_cnt++;
        if (transmit === 1'b1) begin
            tx_cyc_q.push_back(cyc);
            if (ack_q.size() == 0)
                check("unexpected_tx", {24'd0, tx_byte}, 32'hFFFF_FFFF);
            else
                check("ack_byte", {24'd0, tx_byte}, {24'd0, ack_q.pop_front()});
        end
    end

    task automatic drive(input logic [7:0] b, input bit has_ack, input logic [7:0] ack);
        @(negedge clk);
        received = 1'b1;
        rx_byte  = b;
        if (has_ack) ack_q.push_back(ack);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        received = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input bit has_ack, input logic [7:0] ack);
        drive(b, has_ack, ack);
        idle(1);
    endtask

    int set_before;

    initial begin
        #1;
        check("rst_en", {31'd0, en}, 32'd0);
        check("rst_m", m, 32'd0);
        check("rst_set_tx", {30'd0, set, transmit}, 32'd0);
        check("rst_txb", {24'd0, tx_byte}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Load 0x000266AA byte by byte, then commit.
        send(c_CMD_BYTE0, 0, 8'h00); send(8'hAA, 1, c_CMD_BYTE0);
        send(c_CMD_BYTE1, 0, 8'h00); send(8'h66, 1, c_CMD_BYTE1);
        send(c_CMD_BYTE2, 0, 8'h00); send(8'h02, 1, c_CMD_BYTE2);
        send(c_CMD_BYTE3, 0, 8'h00); send(8'h00, 1, c_CMD_BYTE3);
        check("m_before_set", m, 32'd0);
        check("no_set_yet", set_cnt, 0);
        send(c_CMD_SET, 1, c_CMD_SET);
        check("m_loaded", m, 32'h0002_66AA);
        check("one_set_pulse", set_cnt, 1);

        // Enable, status, repeat enable, disable, status.
        send(c_CMD_ENABLE, 1, c_CMD_ENABLE);
        check("en_on", {31'd0, en}, 32'd1);
        send(c_CMD_STATUS, 1, 8'h01);
        send(c_CMD_ENABLE, 1, c_CMD_ENABLE);
        check("en_still_on", {31'd0, en}, 32'd1);
        send(c_CMD_DISABLE, 1, c_CMD_DISABLE);
        check("en_off", {31'd0, en}, 32'd0);
        send(c_CMD_STATUS, 1, 8'h00);

        // A command code sent as data is raw payload and m waits for SET.
        set_before = set_cnt;
        send(c_CMD_BYTE0, 0, 8'h00); send(c_CMD_SET, 1, c_CMD_BYTE0);
        check("m_unchanged", m, 32'h0002_66AA);
        check("no_set_on_data", set_cnt, set_before);
        send(c_CMD_SET, 1, c_CMD_SET);
        check("m_low_05", m, 32'h0002_6605);

        // Unknown code is ignored; the following 05 must still decode as SET.
        send(8'hFF, 0, 8'h00);
        set_before = set_cnt;
        send(c_CMD_SET, 1, c_CMD_SET);
        check("reset_set_pulse", set_cnt, set_before + 1);
        check("m_same_after_reset_set", m, 32'h0002_6605);

        // Asynchronous reset in the middle of a data sequence.
        send(c_CMD_ENABLE, 1, c_CMD_ENABLE);
        send(c_CMD_BYTE1, 0, 8'h00);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_en", {31'd0, en}, 32'd0);
        check("async_m", m, 32'd0);
        check("async_set_tx", {30'd0, set, transmit}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send(c_CMD_SET, 1, c_CMD_SET);
        check("m_after_reset", m, 32'd0);

        // Back-to-back strobes.
        tx_cyc_q.delete();
        drive(c_CMD_BYTE0, 0, 8'h00);
        drive(8'h34, 1, c_CMD_BYTE0);
        drive(c_CMD_SET, 1, c_CMD_SET);
        idle(1);
        check("m_burst", m, 32'h0000_0034);
        check("burst_ack_count", tx_cyc_q.size(), 2);
        if (tx_cyc_q.size() == 2)
            check("burst_ack_spacing", tx_cyc_q[1] - tx_cyc_q[0], 1);

        // Bounded drain of outstanding acks.
        for (int i = 0; i < 20 && ack_q.size() != 0; i++) @(negedge clk);
        check("acks_drained", ack_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
